cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
Run/step clock-enable controller that sits between the board clock and the `computer` core in the top level. It replaces the free-running divider with a parametrised one and adds single-step, halt and a power-on reset sequence for the core. It latches the core's output port onto the LEDs, and counts executed core cycles for debug.

Parameters:
DIV_WIDTH, 25, width of divider counter and `div` input
RST_CYCLES, 16, cycles `cpu_reset` stays high after `reset` deasserts (≥1)
PORT_WIDTH, 8, width of `oport` / `led`
CNT_WIDTH, 16, width of `tick_count`
DEB_CYCLES, 1000, debounce length for `step` (used only with STEP_DEBOUNCE_EN)

Ports:
clk  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-high
run  in  1  level: 1 = free-run the core, 0 = halt
step  in  1  rising edge requests one core cycle while halted
div  in  DIV_WIDTH  divide ratio; cpu_en period = max(div,1) clk cycles
oport  in  PORT_WIDTH  core output port
cpu_en  out  1  one-clk-wide clock-enable pulse to the core
cpu_reset  out  1  synchronous reset to the core
led  out  PORT_WIDTH  registered copy of oport
tick_count  out  CNT_WIDTH  number of cpu_en pulses since reset, wraps
halted  out  1  1 when in HALT state

Behaviour:
- Reset (`reset`=1 at posedge) produces these values on the next cycle:
  - state=RST_HOLD, cpu_reset=1, cpu_en=0, led=0, tick_count=0, halted=0.
  - Divider counter=0, reset counter=0, step edge register=0.
  - Reset mid-operation aborts everything, including a pending step.
- States:
  - RST_HOLD: cpu_reset=1. Count RST_CYCLES clocks after reset deasserts, then go to HALT. cpu_reset is 0 from the first HALT cycle. step/run are ignored here.
  - HALT: cpu_en=0, halted=1, divider counter held at 0.
    - run=1 goes to RUN.
    - Otherwise a step rising edge goes to STEP.
    - run=1 and a step edge in the same cycle: RUN wins and the step is discarded.
  - RUN: halted=0. Divider counts 0..d-1 with d=max(div,1).
    - cpu_en=1 in the cycle where counter==d-1; the counter then wraps to 0.
    - div=0 or 1 gives cpu_en every cycle.
    - div is read live. If div decreases so that counter ≥ d-1, cpu_en fires on the next cycle and the counter wraps.
    - run=0 goes to HALT next cycle, counter cleared, no further cpu_en. A cpu_en in the same cycle run falls still occurs.
    - Step edges in RUN are ignored and not queued.
  - STEP: cpu_en=1 for exactly one cycle, halted=0, then HALT unconditionally.
- Step edge detection:
  - step_q registers step each cycle.
  - Edge = step & ~step_q.
  - Holding step high yields one step only.
- Latencies:
  - STEP: edge sampled in HALT → cpu_en high exactly 1 cycle later.
  - RUN: first cpu_en d cycles after entering RUN.
- led: updates to oport on the clk cycle immediately after each cpu_en pulse (the core updates oport on the enabled edge). Otherwise it holds.
- tick_count: increments by 1 on every cycle with cpu_en=1; wraps 2^CNT_WIDTH-1 → 0.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
STEP_DEBOUNCE_EN
- Defined:
  - step passes through a 2-FF synchronizer, then a debouncer.
  - The filtered level changes only after the synchronized input is stable for DEB_CYCLES consecutive clks.
  - Edge detection runs on the filtered level, adding 2+DEB_CYCLES cycles of step latency.
- Undefined: step goes directly into the edge register as described above. DEB_CYCLES is unused.

Test Plan:
- Reset with RST_CYCLES=16, hold reset 3 cycles then release → cpu_reset=1 for exactly 16 cycles, then 0 with halted=1, cpu_en never high, led=0, tick_count=0.
- HALT, run=1, div=4, 40 cycles → cpu_en pulses every 4th cycle (10 pulses), first at cycle 4 after RUN entry, tick_count=10.
- HALT, step pulsed 0→1 and held high 50 cycles → exactly one cpu_en pulse, one cycle after the edge; tick_count=1; halted returns to 1.
- RUN, div=1 then div=0 → cpu_en every cycle. Then run=0 → cpu_en stops the next cycle and halted=1.
- oport=8'hA5 before cpu_en, changed to 8'h3C one cycle after → led=8'hA5 on the cycle after cpu_en and holds until the next pulse.
- CNT_WIDTH=4, run with div=1 for 17 cycles → tick_count wraps 15→0 and reads 1. Reset asserted mid-run → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step clock-enable controller for the computer core.
//
// Produces a one-clk-wide cpu_en pulse for the core, either free-running
// at a live-programmable divide ratio (RUN) or one pulse per step request
// (HALT -> STEP -> HALT). After reset the core is held in cpu_reset for
// RST_CYCLES clocks. The core's output port is captured onto led on the
// cycle after each enable pulse, and enable pulses are counted in
// tick_count.
//
// Build option: define STEP_DEBOUNCE_EN to pass step through a 2-FF
// synchronizer and a DEB_CYCLES debouncer before edge detection. Without
// it, step feeds the edge register directly and DEB_CYCLES is unused.
//
// Timing: every output is a flop. cpu_en is computed from the next state
// and the divider counter, so the first RUN pulse appears d = max(div,1)
// cycles after RUN is entered, and a step edge sampled in HALT shows up as
// cpu_en one cycle later (concurrent with the STEP state).

module cpu_clk_ctrl #(
    parameter int DIV_WIDTH  = 25,
    parameter int RST_CYCLES = 16,
    parameter int PORT_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int DEB_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [PORT_WIDTH-1:0] oport,
    output logic                  cpu_en,
    output logic                  cpu_reset,
    output logic [PORT_WIDTH-1:0] led,
    output logic [CNT_WIDTH-1:0]  tick_count,
    output logic                  halted
);

    // Reset-hold counter runs 0..RST_CYCLES-1; at least one bit wide.
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RST_HOLD = 2'd0,
        S_HALT     = 2'd1,
        S_RUN      = 2'd2,
        S_STEP     = 2'd3
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [RST_W-1:0]       rst_cnt_reg;
    logic [RST_W-1:0]       rst_cnt_next;
    logic [DIV_WIDTH-1:0]   div_cnt_reg;
    logic [DIV_WIDTH-1:0]   div_cnt_next;
    logic                   cpu_en_reg;
    logic                   cpu_en_next;
    logic                   cpu_reset_reg;
    logic                   halted_reg;
    logic [PORT_WIDTH-1:0]  led_reg;
    logic [CNT_WIDTH-1:0]   tick_reg;
    logic                   step_q_reg;

    logic                   step_level;
    logic                   step_edge;
    logic [DIV_WIDTH-1:0]   div_last;

    // ------------------------------------------------------------------
    // Step conditioning: either raw, or synchronized and debounced.
    // ------------------------------------------------------------------
`ifdef STEP_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             filt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            // Two-stage synchronizer chain for the asynchronous push button.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= step;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    // Debouncer: filtered level follows only after DEB_CYCLES stable clks.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_reg <= '0;
            filt_reg    <= 1'b0;
        end else if (sync_reg[1] == filt_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
            deb_cnt_reg <= '0;
            filt_reg    <= sync_reg[1];
        end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
    end

    assign step_level = filt_reg;
`else
    assign step_level = step;
`endif

    // A step request is a rising edge of the conditioned level; holding
    // the button down therefore yields a single step.
    assign step_edge = step_level & ~step_q_reg;

    // Terminal divider count for d = max(div,1); div is read live.
    assign div_last = (div == '0) ? '0 : div - DIV_WIDTH'(1);

    // ------------------------------------------------------------------
    // Next-state, counters and enable pulse generation.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        div_cnt_next = div_cnt_reg;
        cpu_en_next  = 1'b0;

        case (state_reg)
            S_RST_HOLD: begin
                // run/step are ignored while the core is held in reset.
                div_cnt_next = '0;
                if (rst_cnt_reg == RST_LAST) begin
                    state_next   = S_HALT;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RST_W'(1);
                end
            end

            S_HALT: begin
                div_cnt_next = '0;
                // run has priority; a simultaneous step edge is dropped.
                if (run) begin
                    state_next = S_RUN;
                end else if (step_edge) begin
                    state_next  = S_STEP;
                    cpu_en_next = 1'b1;
                end
            end

            S_RUN: begin
                // Step edges are neither acted on nor queued here.
                if (!run) begin
                    state_next   = S_HALT;
                    div_cnt_next = '0;
                end else if (div_cnt_reg >= div_last) begin
                    // >= so that a live decrease of div fires and wraps at once.
                    div_cnt_next = '0;
                    cpu_en_next  = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_WIDTH'(1);
                end
            end

            S_STEP: begin
                state_next   = S_HALT;
                div_cnt_next = '0;
            end

            default: begin
                state_next   = S_RST_HOLD;
                rst_cnt_next = '0;
                div_cnt_next = '0;
            end
        endcase
    end

    // State, counters and all registered outputs; reset aborts everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_RST_HOLD;
            rst_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
            step_q_reg    <= 1'b0;
            cpu_en_reg    <= 1'b0;
            cpu_reset_reg <= 1'b1;
            halted_reg    <= 1'b0;
            led_reg       <= '0;
            tick_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            div_cnt_reg   <= div_cnt_next;
            step_q_reg    <= step_level;
            cpu_en_reg    <= cpu_en_next;
            cpu_reset_reg <= (state_next == S_RST_HOLD);
            halted_reg    <= (state_next == S_HALT);
            // The core drives oport on its enabled edge, so capture it on
            // the edge that closes each cpu_en cycle.
            if (cpu_en_reg) begin
                led_reg  <= oport;
                tick_reg <= tick_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign cpu_en     = cpu_en_reg;
    assign cpu_reset  = cpu_reset_reg;
    assign halted     = halted_reg;
    assign led        = led_reg;
    assign tick_count = tick_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Testbench for cpu_clk_ctrl: a driver applies one input vector per clock
// and advances a behavioural model of the controller, pushing the expected
// outputs into a queue; a monitor pops one entry after every clock edge and
// compares it with the DUT outputs.

module tb_cpu_clk_ctrl;

    localparam int DW = 25;
    localparam int RC = 16;
    localparam int PW = 8;
    localparam int CW = 4;

    // Model operating modes.
    localparam int M_HOLD = 0;
    localparam int M_HALT = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic [DW-1:0] div = '0;
    logic [PW-1:0] oport = '0;
    logic          cpu_en;
    logic          cpu_reset;
    logic [PW-1:0] led;
    logic [CW-1:0] tick_count;
    logic          halted;

    cpu_clk_ctrl #(
        .DIV_WIDTH (DW),
        .RST_CYCLES(RC),
        .PORT_WIDTH(PW),
        .CNT_WIDTH (CW),
        .DEB_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .div       (div),
        .oport     (oport),
        .cpu_en    (cpu_en),
        .cpu_reset (cpu_reset),
        .led       (led),
        .tick_count(tick_count),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          crst;
        logic          hlt;
        logic [PW-1:0] led;
        logic [CW-1:0] tick;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state.
    int   m_mode = M_HOLD;
    int   m_hold = 0;       // clocks spent in reset hold so far
    int   m_elapsed = 0;    // clocks since RUN entry or last RUN pulse
    logic m_step_prev = 1'b0;
    exp_t m_out = '{1'b0, 1'b1, 1'b0, '0, '0};
    int   cyc_no = 0;

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_clock(input logic r, input logic rn, input logic st,
                               input int dv, input logic [PW-1:0] op);
        exp_t nxt;
        int   d;
        logic edge_seen;
        d = (dv < 1) ? 1 : dv;
        if (r) begin
            m_mode      = M_HOLD;
            m_hold      = 0;
            m_elapsed   = 0;
            m_step_prev = 1'b0;
            nxt.en      = 1'b0;
            nxt.crst    = 1'b1;
            nxt.hlt     = 1'b0;
            nxt.led     = '0;
            nxt.tick    = '0;
        end else begin
            nxt.led  = m_out.en ? op : m_out.led;
            nxt.tick = m_out.en ? CW'(int'(m_out.tick) + 1) : m_out.tick;
            edge_seen   = st && !m_step_prev;
            m_step_prev = st;
            nxt.en = 1'b0;
            case (m_mode)
                M_HOLD: begin
                    m_hold++;
                    if (m_hold == RC) m_mode = M_HALT;
                end
                M_HALT: begin
                    if (rn) begin
                        m_mode    = M_RUN;
                        m_elapsed = 0;
                    end else if (edge_seen) begin
                        m_mode = M_STEP;
                        nxt.en = 1'b1;
                    end
                end
                M_RUN: begin
                    if (!rn) begin
                        m_mode = M_HALT;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed >= d) begin
                            nxt.en    = 1'b1;
                            m_elapsed = 0;
                        end
                    end
                end
                default: m_mode = M_HALT;
            endcase
            nxt.crst = (m_mode == M_HOLD);
            nxt.hlt  = (m_mode == M_HALT);
        end
        m_out = nxt;
    endtask

    // Drive one input vector for the next clock edge and queue the expectation.
    task automatic apply(input logic r, input logic rn, input logic st,
                         input int dv, input logic [PW-1:0] op);
        @(negedge clk);
        reset = r;
        run   = rn;
        step  = st;
        div   = DW'(dv);
        oport = op;
        model_clock(r, rn, st, dv, op);
        exp_q.push_back(m_out);
    endtask

    // Monitor: one comparison per clock edge once expectations exist.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                bad = 1'b0;
                cyc_no++;
                vectors++;
                if (cpu_en !== e.en) begin
                    $display("FAIL cpu_en cycle %0d: got %b expected %b", cyc_no, cpu_en, e.en);
                    bad = 1'b1;
                end
                if (cpu_reset !== e.crst) begin
                    $display("FAIL cpu_reset cycle %0d: got %b expected %b", cyc_no, cpu_reset, e.crst);
                    bad = 1'b1;
                end
                if (halted !== e.hlt) begin
                    $display("FAIL halted cycle %0d: got %b expected %b", cyc_no, halted, e.hlt);
                    bad = 1'b1;
                end
                if (led !== e.led) begin
                    $display("FAIL led cycle %0d: got %h expected %h", cyc_no, led, e.led);
                    bad = 1'b1;
                end
                if (tick_count !== e.tick) begin
                    $display("FAIL tick_count cycle %0d: got %0d expected %0d", cyc_no, tick_count, e.tick);
                    bad = 1'b1;
                end
                if (bad) miscompares++;
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        logic          rn;
        logic          st;
        int            dv;
        logic [PW-1:0] op;

        // Reset held three cycles, then the hold sequence with step pokes.
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 0, 8'h00);
        for (int i = 0; i < 24; i++) apply(1'b0, 1'b0, (i == 5 || i == 6), 0, 8'h11);

        // Free run at div=4 for 40 cycles, then halt.
        for (int i = 0; i < 40; i++) apply(1'b0, 1'b1, 1'b0, 4, 8'(i));
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 4, 8'h00);

        // Single step with the button held for 50 cycles.
        for (int i = 0; i < 50; i++) apply(1'b0, 1'b0, 1'b1, 4, 8'h77);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 4, 8'h00);

        // div=1 then div=0 (enable every cycle), then stop.
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 1'b0, 1, 8'h20);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 1'b0, 0, 8'h21);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 0, 8'h00);

        // led capture: A5 while cpu_en is high, 3C on every other cycle.
        for (int i = 0; i < 24; i++) apply(1'b0, 1'b1, 1'b0, 5, m_out.en ? 8'hA5 : 8'h3C);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 5, 8'h3C);

        // tick_count wrap through 15 -> 0 with div=1.
        for (int i = 0; i < 17; i++) apply(1'b0, 1'b1, 1'b0, 1, 8'(8'h40 + i));

        // Reset mid-run, then recover and keep running.
        apply(1'b1, 1'b1, 1'b1, 1, 8'h99);
        for (int i = 0; i < 25; i++) apply(1'b0, 1'b1, 1'b0, 2, 8'h55);

        // Randomized soak with live div changes, step traffic and rare resets.
        rn = 1'b0;
        st = 1'b0;
        dv = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rn = ~rn;
            if ($urandom_range(0, 3) == 0) st = ~st;
            if ($urandom_range(0, 7) == 0) dv = $urandom_range(0, 6);
            op = 8'($urandom);
            apply(($urandom_range(0, 199) == 0), rn, st, dv, op);
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard drain: got %0d entries left expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
